// File: rtl/gpu_pkg.sv
// Shared GPU-side constants and types for the frame-buffer to VGA path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gpu_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PIX_W       = 16;
    localparam int READ_CYCLES = 3;

    typedef logic [PIX_W-1:0] pixel_t;

    // Capture sequencer states: IDLE between lines, FETCH while the
    // controller holds the read phase open.
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } cap_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Line FIFO storage: simple dual-port RAM with a registered read port.
// Latency: write lands on the next edge; read data appears one cycle after rd_en_i.
// Backpressure: none; the caller guarantees no write to a full FIFO and no read of an empty one.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_dat_i   write port
//   rd_en_i/rd_addr_i       read port; rd_dat_o loads mem[rd_addr_i]
//   rd_zero_i               load rd_dat_o with 0 instead (underflow -> black pixel)
//   rd_dat_o                registered read data, holds when neither strobe is set
module sync_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]          wr_dat_i,
    input  logic                       rd_en_i,
    input  logic                       rd_zero_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]          rd_dat_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_dat_q;

    // The array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end else if (rd_zero_i) begin
            rd_dat_q <= '0;
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/line_fifo_loader.sv
// Captures one SRAM word per READ_CYCLES clocks into a line FIFO and pops pixels for VGA output.
// Latency: pushed word is poppable next cycle; popped pixel appears on pixel_out one cycle after the pop.
// Backpressure: none; pushes while full are dropped (overflow), pops while empty return black (underflow).
//
// Ports:
//   Clk, Reset_N            clock, async active-low reset
//   fifo_we, sram_rdata     controller read phase and SRAM data (valid on last slot cycle)
//   flush                   synchronous pointer/count clear, wins over push/pop
//   pix_en, VGA_BLANK_N, PauseVGA   pop qualifiers from VGA timing
//   clear_flags             clears sticky overflow/underflow
//   pixel_out, pixel_valid  registered pixel and its valid strobe
//   count, empty, full      fill level
//   overflow, underflow     sticky error flags
//   line_loaded             one-cycle pulse after fifo_we falls
module line_fifo_loader #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int READ_CYCLES = 3
) (
    input  logic                      Clk,
    input  logic                      Reset_N,
    input  logic                      fifo_we,
    input  logic [DATA_W-1:0]         sram_rdata,
    input  logic                      flush,
    input  logic                      pix_en,
    input  logic                      VGA_BLANK_N,
    input  logic                      PauseVGA,
    input  logic                      clear_flags,
    output logic [DATA_W-1:0]         pixel_out,
    output logic                      pixel_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      line_loaded
);

    import gpu_pkg::*;

    localparam int AW  = $clog2(DEPTH);
    localparam int PHW = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

    localparam logic [PHW-1:0] PH_LAST  = PHW'(READ_CYCLES - 1);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Capture sequencer
    // ------------------------------------------------------------------
    cap_state_t     state_q;
    logic [PHW-1:0] phase_q;
    logic [PHW-1:0] phase_inc;
    logic           fifo_we_dly_q;
    logic           line_loaded_q;
    logic           push;

    assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);

    // The first cycle fifo_we is seen high is slot phase 0, so a line of
    // N*READ_CYCLES enable cycles yields exactly N pushes.
    assign push = fifo_we & (phase_q == PH_LAST);

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            fifo_we_dly_q <= 1'b0;
            line_loaded_q <= 1'b0;
        end else begin
            fifo_we_dly_q <= fifo_we;
            line_loaded_q <= fifo_we_dly_q & ~fifo_we;
            unique case (state_q)
                IDLE: begin
                    if (fifo_we) begin
                        state_q <= FETCH;
                        phase_q <= phase_inc;
                    end
                end
                FETCH: begin
                    if (!fifo_we) begin
                        // A partially completed slot is abandoned.
                        state_q <= IDLE;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= '0;
                end
            endcase
            if (flush) begin
                phase_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count and flags
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic pop;
    logic empty_w;
    logic full_w;
    logic push_ok;
    logic pop_ok;
    logic push_drop;
    logic pop_drop;

    assign pop     = pix_en & VGA_BLANK_N & ~PauseVGA;
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_FULL);

    // Full/empty are judged on the pre-update count, so a push against a
    // full FIFO is dropped even when a pop frees a slot in the same cycle.
    assign push_ok   = push & ~full_w  & ~flush;
    assign pop_ok    = pop  & ~empty_w & ~flush;
    assign push_drop = push &  full_w  & ~flush;
    assign pop_drop  = pop  &  empty_w & ~flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pixel_valid_d = pop_ok;
        overflow_d    = (overflow_q  & ~clear_flags) | push_drop;
        underflow_d   = (underflow_q & ~clear_flags) | pop_drop;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pixel_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pixel_valid_q <= pixel_valid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage; its read register doubles as the pixel_out register.
    // ------------------------------------------------------------------
    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i     (Clk),
        .rst_n_i   (Reset_N),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (sram_rdata),
        .rd_en_i   (pop_ok),
        .rd_zero_i (pop_drop),
        .rd_addr_i (rd_ptr_q),
        .rd_dat_o  (pixel_out)
    );

    assign pixel_valid = pixel_valid_q;
    assign count       = count_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign line_loaded = line_loaded_q;

endmodule

// File: tb/tb_line_fifo_loader.sv
// Self-checking bench for line_fifo_loader: queue-based reference model plus directed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_line_fifo_loader;

    localparam int DW    = 16;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_we = 1'b0;
    logic [DW-1:0] sram_rdata = '0;
    logic          flush = 1'b0;
    logic          pix_en = 1'b0;
    logic          blank_n = 1'b1;
    logic          pause = 1'b0;
    logic          clear_flags = 1'b0;
    logic [DW-1:0] pixel_out;
    logic          pixel_valid;
    logic [10:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic          line_loaded;

    always #5 clk = ~clk;

    line_fifo_loader #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .READ_CYCLES (3)
    ) dut (
        .Clk         (clk),
        .Reset_N     (rst_n),
        .fifo_we     (fifo_we),
        .sram_rdata  (sram_rdata),
        .flush       (flush),
        .pix_en      (pix_en),
        .VGA_BLANK_N (blank_n),
        .PauseVGA    (pause),
        .clear_flags (clear_flags),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .line_loaded (line_loaded)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of words, a run-length counter of fifo_we,
    // and plain flag bits. A slot completes on every third enabled cycle.
    // ------------------------------------------------------------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_pix;
    bit            m_vld, m_ovf, m_udf, m_ll, m_prev_we;
    int            m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pix = '0;
            m_vld = 0; m_ovf = 0; m_udf = 0; m_ll = 0; m_prev_we = 0;
            m_run = 0;
        end else begin : model_step
            bit do_push, do_pop, was_full, was_empty;
            do_push   = fifo_we && (m_run % 3 == 2);
            do_pop    = pix_en && blank_n && !pause;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (clear_flags) begin
                m_ovf = 0;
                m_udf = 0;
            end
            m_ll      = m_prev_we && !fifo_we;
            m_prev_we = fifo_we;
            if (flush) begin
                mq.delete();
                m_vld = 0;
                m_run = 0;
            end else begin
                if (do_pop) begin
                    if (!was_empty) begin
                        m_pix = mq.pop_front();
                        m_vld = 1;
                    end else begin
                        m_pix = '0;
                        m_vld = 0;
                        m_udf = 1;
                    end
                end else begin
                    m_vld = 0;
                end
                if (do_push) begin
                    if (!was_full) mq.push_back(sram_rdata);
                    else           m_ovf = 1;
                end
                m_run = fifo_we ? m_run + 1 : 0;
            end
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count",       32'(count),       32'(mq.size()));
            check("empty",       32'(empty),       32'(mq.size() == 0));
            check("full",        32'(full),        32'(mq.size() == DEPTH));
            check("overflow",    32'(overflow),    32'(m_ovf));
            check("underflow",   32'(underflow),   32'(m_udf));
            check("line_loaded", 32'(line_loaded), 32'(m_ll));
            check("pixel_valid", 32'(pixel_valid), 32'(m_vld));
            check("pixel_out",   32'(pixel_out),   32'(m_pix));
        end
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);
        check("rst_pix",   32'(pixel_out), 0);
        check("rst_vld",   32'(pixel_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // One full line: 1920 enable cycles, data = slot index.
        for (int i = 0; i < 1920; i++) begin
            fifo_we    = 1'b1;
            sram_rdata = DW'(i / 3);
            @(negedge clk);
        end
        fifo_we = 1'b0;
        check("line_count", 32'(count), 640);
        check("ll_before",  32'(line_loaded), 0);
        @(negedge clk);
        check("ll_pulse",   32'(line_loaded), 1);
        @(negedge clk);
        check("ll_after",   32'(line_loaded), 0);

        // Drain the line, one pop per cycle.
        pix_en = 1'b1;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            check("drain_pix", 32'(pixel_out), 32'(i));
            check("drain_vld", 32'(pixel_valid), 1);
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_udf",   32'(underflow), 0);
        @(negedge clk);
        pix_en = 1'b0;
        check("extra_pix", 32'(pixel_out), 0);
        check("extra_vld", 32'(pixel_valid), 0);
        check("extra_udf", 32'(underflow), 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("clr_udf", 32'(underflow), 0);

        // Overfill: 1025 slots into a 1024-entry FIFO.
        for (int i = 0; i < 3 * 1025; i++) begin
            fifo_we    = 1'b1;
            sram_rdata = DW'(i / 3);
            @(negedge clk);
        end
        fifo_we = 1'b0;
        @(negedge clk);
        check("ovf_count", 32'(count), 1024);
        check("ovf_full",  32'(full), 1);
        check("ovf_flag",  32'(overflow), 1);
        pix_en = 1'b1;
        repeat (1024) @(negedge clk);
        pix_en = 1'b0;
        check("ovf_last", 32'(pixel_out), 1023);
        check("ovf_empty", 32'(empty), 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;

        // Fill five entries (100..104), then push and pop together.
        for (int i = 0; i < 15; i++) begin
            fifo_we    = 1'b1;
            sram_rdata = DW'(100 + i / 3);
            @(negedge clk);
        end
        fifo_we = 1'b0;
        @(negedge clk);
        check("five_count", 32'(count), 5);
        fifo_we    = 1'b1;
        sram_rdata = DW'(200);
        repeat (2) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        fifo_we = 1'b0;
        pix_en  = 1'b0;
        check("both_count", 32'(count), 5);
        check("both_pix",   32'(pixel_out), 100);
        @(negedge clk);

        // Partial slot: enable dropped at phase 1.
        fifo_we = 1'b1;
        repeat (2) @(negedge clk);
        fifo_we = 1'b0;
        @(negedge clk);
        check("partial_count", 32'(count), 5);

        // Flush coinciding with a pop.
        flush  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        flush  = 1'b0;
        pix_en = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_vld",   32'(pixel_valid), 0);
        check("flush_pix",   32'(pixel_out), 100);

        // Reset mid-fetch with traffic.
        for (int i = 0; i < 20; i++) begin
            fifo_we    = 1'b1;
            sram_rdata = DW'($urandom);
            pix_en     = (i > 8) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_pix",   32'(pixel_out), 0);
        check("arst_vld",   32'(pixel_valid), 0);
        check("arst_flags", 32'({overflow, underflow, line_loaded, full}), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pix_en = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 3) fifo_we = ~fifo_we;
            sram_rdata  = DW'($urandom);
            pix_en      = ($urandom_range(0, 99) < 30);
            blank_n     = ($urandom_range(0, 99) < 85);
            pause       = ($urandom_range(0, 99) < 5);
            flush       = ($urandom_range(0, 999) < 4);
            clear_flags = ($urandom_range(0, 999) < 10);
            @(negedge clk);
        end
        fifo_we = 1'b0; pix_en = 1'b0; flush = 1'b0; clear_flags = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_fifo_loader.md
Name: line_fifo_loader

Overview:
- Sits between the SRAM frame buffer and the VGA colour path.
- While the GPU controller holds fifo_we high, the block samples SRAM read data on a fixed 3-cycle cadence and pushes one pixel per 3 cycles into an internal line FIFO.
- During active video it pops one pixel per pixel-enable and presents it to the colour mapper.
- It reports fill level plus sticky overflow/underflow so line-timing errors are visible.

Parameters:
- DATA_W, 16, SRAM word / pixel width.
- DEPTH, 1024, FIFO entries; must be a power of 2 and at least 640.
- READ_CYCLES, 3, clocks per SRAM read; a push happens on the last cycle.
- AW, $clog2(DEPTH), pointer width (derived, not overridable).

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  asynchronous, active-low reset.
- fifo_we  in  1  controller read-phase enable; held high for the whole line fetch.
- sram_rdata  in  DATA_W  SRAM data bus, valid on the last cycle of each read slot.
- flush  in  1  synchronous pointer/count clear (pulse on flip_page toggle or frame start).
- pix_en  in  1  pixel-clock enable from VGA timing.
- VGA_BLANK_N  in  1  high = active video.
- PauseVGA  in  1  high = VGA halted; no pops.
- clear_flags  in  1  clears sticky flags.
- pixel_out  out  DATA_W  current pixel to colour mapper.
- pixel_valid  out  1  pixel_out holds popped data this cycle.
- count  out  AW+1  entries held.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- line_loaded  out  1  one-cycle pulse on the falling edge of fifo_we.

Behaviour:
- Reset (async, Reset_N low): all of the following are 0 immediately:
  - read and write pointers, count, phase, pixel_out, pixel_valid
  - overflow, underflow, line_loaded, fifo_we_d
  - empty is 1; full is 0.
- Capture sequencer:
  - States are IDLE and FETCH.
  - IDLE→FETCH when fifo_we=1; phase=0.
  - In FETCH, phase counts 0..READ_CYCLES-1 and wraps.
  - push = (phase==READ_CYCLES-1); sram_rdata is sampled in that same cycle.
  - FETCH→IDLE when fifo_we=0; phase→0. A partial slot is discarded, with no push.
  - line_loaded = fifo_we_d & ~fifo_we, registered one cycle after fifo_we falls.
- Pop condition: pop = pix_en & VGA_BLANK_N & ~PauseVGA.
- Write: on push & ~full, mem[wr_ptr] ← sram_rdata and wr_ptr += 1, wrapping modulo DEPTH.
- Push while full: data is dropped, pointers are unchanged, overflow←1.
- Read, registered with 1-cycle latency:
  - on pop & ~empty: pixel_out ← mem[rd_ptr], rd_ptr += 1, pixel_valid←1.
  - on pop & empty: pixel_out ← 0 (black), pixel_valid←0, underflow←1.
  - no pop: pixel_out holds its value and pixel_valid←0.
- Count update:
  - push-only: +1.
  - pop-only: -1.
  - both in the same cycle, with neither blocked: unchanged, and both pointers advance.
  - simultaneous push while full and pop: pop proceeds, push is still dropped, and overflow is set. The full flag is evaluated pre-update.
  - count never exceeds DEPTH and never wraps below 0.
- flush:
  - clears pointers, count, phase and pixel_valid in the next cycle.
  - takes priority over push and pop in the same cycle.
  - does not clear sticky flags.
- clear_flags: overflow and underflow ← 0. A new error in the same cycle wins, so the flag stays 1.
- Memory: inferred simple dual-port RAM, write-first not required; read and write addresses never collide while the FIFO is not empty.
- Reset mid-line: the FIFO becomes empty. The next fifo_we assertion starts a fresh slot at phase 0.

Decomposition:
- gpu_pkg holds:
  - localparams for screen width (640) and height (480)
  - PIX_W=16
  - READ_CYCLES=3
  - typedef pixel_t (logic [PIX_W-1:0])
  - the capture state enum {IDLE, FETCH}
- One sub-module, sync_fifo_mem: parameterised DATA_W/DEPTH storage with registered read port.
- Pointer, count and flag logic stays in line_fifo_loader.

Test Plan:
- Reset with fifo_we high for 1920 cycles, sram_rdata = slot index → exactly 640 pushes, count=640, line_loaded pulses once, 1 cycle after fifo_we falls.
- After that fill, VGA_BLANK_N=1, PauseVGA=0, pix_en every cycle for 640 cycles → pixel_out reads 0,1,…,639 with 1-cycle latency, empty=1 at end, underflow=0.
- One extra pop after empty → pixel_out=0, pixel_valid=0, underflow=1. Then clear_flags → underflow=0.
- fifo_we high for 3·1025 cycles with DEPTH=1024 and no pops → count=1024, full=1, overflow=1, last word not stored.
- Simultaneous push and pop at count=5 → count stays 5, popped data is the oldest entry.
- fifo_we dropped at phase 1 → no push; flush during pop → count=0 next cycle. Reset_N pulsed low mid-fetch → all outputs 0 asynchronously.
